// File: rtl/lzw_dict_ram.sv
// -----------------------------------------------------------------------------
// lzw_dict_ram
// LZW dictionary store on a single-port synchronous RAM. Adds per-entry valid
// bits, an append-allocation pointer, a linear content search and a one-cycle
// dictionary clear.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req, op, addr,    operation request (READ/WRITE/APPEND/SEARCH), accepted
//   data_in           in IDLE when req && !clr; op/addr/data_in sampled then
//   clr               clear all valid bits and rewind next_code (IDLE only)
//   busy              operation in flight
//   done              one-cycle completion pulse
//   data_out, map_out,
//   valid             result of the last completed operation, held until next done
//   full              append pointer has reached DEPTH
//   next_code         append pointer
// -----------------------------------------------------------------------------
module lzw_dict_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4096,
    parameter int FIRST_FREE = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] map_out,
    output logic                  valid,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   next_code
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_APPEND = 2'b10;
    localparam logic [1:0] OP_SEARCH = 2'b11;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   FIRST_C = (ADDR_WIDTH+1)'(FIRST_FREE);
    localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q_r;

    logic [1:0]            state_r;
    logic [1:0]            op_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] key_r;
    logic                  app_ok_r;
    logic                  vq_r;
    logic [DEPTH-1:0]      vbit_r;
    logic [ADDR_WIDTH:0]   next_code_r;
    logic [ADDR_WIDTH:0]   scan_idx_r;
    logic                  cmp_v_r;
    logic [ADDR_WIDTH-1:0] cmp_idx_r;
    logic [DATA_WIDTH-1:0] hold_data_r;
    logic [ADDR_WIDTH-1:0] hold_map_r;
    logic                  hold_valid_r;

    logic                  accept_s;
    logic                  full_s;
    logic                  scan_issue_s;
    logic                  ram_we_s;
    logic                  ram_re_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;
    logic                  match_s;
    logic                  last_s;
    logic                  done_s;
    logic [DATA_WIDTH-1:0] res_data_s;
    logic [ADDR_WIDTH-1:0] res_map_s;
    logic                  res_valid_s;

    // clr has priority over req; both are only looked at in IDLE
    assign accept_s     = (state_r == ST_IDLE) && req && !clr;
    assign full_s       = (next_code_r == DEPTH_C);
    assign scan_issue_s = (state_r == ST_SCAN) && (scan_idx_r < DEPTH_C);
    // The valid bit travels with the RAM read so compare sees a matched pair
    assign match_s      = cmp_v_r && vq_r && (ram_q_r == key_r);
    assign last_s       = cmp_v_r && (cmp_idx_r == LAST_C);

    // RAM port steering: accepted request has the port, otherwise the scanner
    always_comb begin
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_addr_s  = addr;
        ram_wdata_s = data_in;
        if (accept_s) begin
            case (op)
                OP_READ:  ram_re_s = 1'b1;
                OP_WRITE: ram_we_s = 1'b1;
                OP_APPEND: begin
                    if (!full_s) begin
                        ram_we_s   = 1'b1;
                        ram_addr_s = next_code_r[ADDR_WIDTH-1:0];
                    end else begin
                        ram_we_s   = 1'b0;
                    end
                end
                default:  ram_re_s = 1'b0;
            endcase
        end else if (scan_issue_s) begin
            ram_re_s   = 1'b1;
            ram_addr_s = scan_idx_r[ADDR_WIDTH-1:0];
        end else begin
            ram_re_s   = 1'b0;
        end
    end

    // Completion and result selection; results show in the done cycle itself
    always_comb begin
        done_s      = 1'b0;
        res_data_s  = hold_data_r;
        res_map_s   = hold_map_r;
        res_valid_s = hold_valid_r;
        case (state_r)
            ST_ACCESS: begin
                done_s = 1'b1;
                case (op_r)
                    OP_READ: begin
                        res_data_s  = ram_q_r;
                        res_map_s   = addr_r;
                        res_valid_s = vq_r;
                    end
                    OP_WRITE: begin
                        res_data_s  = key_r;
                        res_map_s   = addr_r;
                        res_valid_s = 1'b1;
                    end
                    OP_APPEND: begin
                        if (app_ok_r) begin
                            res_data_s  = key_r;
                            res_map_s   = addr_r;
                            res_valid_s = 1'b1;
                        end else begin
                            res_data_s  = '0;
                            res_map_s   = '0;
                            res_valid_s = 1'b0;
                        end
                    end
                    default: begin
                        res_data_s  = '0;
                        res_map_s   = '0;
                        res_valid_s = 1'b0;
                    end
                endcase
            end
            ST_SCAN: begin
                if (match_s) begin
                    done_s      = 1'b1;
                    res_data_s  = key_r;
                    res_map_s   = cmp_idx_r;
                    res_valid_s = 1'b1;
                end else if (last_s) begin
                    done_s      = 1'b1;
                    res_data_s  = '0;
                    res_map_s   = '0;
                    res_valid_s = 1'b0;
                end else begin
                    done_s      = 1'b0;
                end
            end
            default: done_s = 1'b0;
        endcase
    end

    assign done      = done_s;
    assign data_out  = res_data_s;
    assign map_out   = res_map_s;
    assign valid     = res_valid_s;
    assign busy      = (state_r != ST_IDLE);
    assign full      = full_s;
    assign next_code = next_code_r;

    // Dictionary storage: plain single-port synchronous RAM, contents not reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[ram_addr_s] <= ram_wdata_s;
        end
        if (ram_re_s) begin
            ram_q_r <= mem[ram_addr_s];
        end
    end

    // Control FSM, valid bits, append pointer, scanner and result hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_READ;
            addr_r       <= '0;
            key_r        <= '0;
            app_ok_r     <= 1'b0;
            vq_r         <= 1'b0;
            vbit_r       <= '0;
            next_code_r  <= FIRST_C;
            scan_idx_r   <= '0;
            cmp_v_r      <= 1'b0;
            cmp_idx_r    <= '0;
            hold_data_r  <= '0;
            hold_map_r   <= '0;
            hold_valid_r <= 1'b0;
        end else begin
            if (ram_re_s) begin
                vq_r <= vbit_r[ram_addr_s];
            end
            case (state_r)
                ST_IDLE: begin
                    if (clr) begin
                        vbit_r      <= '0;
                        next_code_r <= FIRST_C;
                    end else if (req) begin
                        op_r       <= op;
                        key_r      <= data_in;
                        app_ok_r   <= !full_s;
                        addr_r     <= (op == OP_APPEND) ? next_code_r[ADDR_WIDTH-1:0] : addr;
                        scan_idx_r <= '0;
                        cmp_v_r    <= 1'b0;
                        if (op == OP_WRITE) begin
                            vbit_r[addr] <= 1'b1;
                        end
                        if ((op == OP_APPEND) && !full_s) begin
                            vbit_r[next_code_r[ADDR_WIDTH-1:0]] <= 1'b1;
                            next_code_r <= next_code_r + ONE_C;
                        end
                        state_r <= (op == OP_SEARCH) ? ST_SCAN : ST_ACCESS;
                    end
                end
                ST_ACCESS: state_r <= ST_IDLE;
                ST_SCAN: begin
                    cmp_v_r <= scan_issue_s;
                    if (scan_issue_s) begin
                        cmp_idx_r  <= scan_idx_r[ADDR_WIDTH-1:0];
                        scan_idx_r <= scan_idx_r + ONE_C;
                    end
                    if (done_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            if (done_s) begin
                hold_data_r  <= res_data_s;
                hold_map_r   <= res_map_s;
                hold_valid_r <= res_valid_s;
            end
        end
    end

endmodule

// File: tb/tb_lzw_dict_ram.sv
// -----------------------------------------------------------------------------
// tb_lzw_dict_ram
// Self-checking bench for lzw_dict_ram. Each scenario task pushes the expected
// result of every request onto a scoreboard queue; a monitor pops and compares
// on every done pulse. Tasks also check latency, pointer and status inline.
// -----------------------------------------------------------------------------
module tb_lzw_dict_ram;

    localparam int AW = 12;
    localparam int DW = 64;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_APPEND = 2'b10;
    localparam logic [1:0] OP_SEARCH = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          clr;
    logic          busy;
    logic          done;
    logic [DW-1:0] data_out;
    logic [AW-1:0] map_out;
    logic          valid;
    logic          full;
    logic [AW:0]   next_code;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] map;
        logic [DW-1:0] data;
        logic          chk_data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   done_prev = 1'b0;

    lzw_dict_ram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4096), .FIRST_FREE(256)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr),
        .data_in(data_in), .clr(clr), .busy(busy), .done(done),
        .data_out(data_out), .map_out(map_out), .valid(valid),
        .full(full), .next_code(next_code)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every done pops one expectation
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (done === 1'b1 && done_prev) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_twice: done high on two consecutive cycles");
            end
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with no outstanding request");
                end else begin
                    mon_e = sb_q.pop_front();
                    n_cmp++;
                    if (valid !== mon_e.valid) begin
                        n_fail++;
                        $display("FAIL result_valid: got %0b expected %0b", valid, mon_e.valid);
                    end
                    n_cmp++;
                    if (map_out !== mon_e.map) begin
                        n_fail++;
                        $display("FAIL result_map: got %0h expected %0h", map_out, mon_e.map);
                    end
                    if (mon_e.chk_data) begin
                        n_cmp++;
                        if (data_out !== mon_e.data) begin
                            n_fail++;
                            $display("FAIL result_data: got %0h expected %0h", data_out, mon_e.data);
                        end
                    end
                end
            end
            done_prev = (done === 1'b1);
        end else begin
            done_prev = 1'b0;
        end
    end

    // Present one request for exactly one cycle; returns just after the accept edge
    task automatic issue(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req = 1'b1; op = o; addr = a; data_in = d;
        @(posedge clk);
        #1;
        req = 1'b0; op = OP_READ; addr = '0; data_in = '0;
    endtask

    // Count cycles after the accept edge until done; lat=-1 when the bound expires
    task automatic wait_done(input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = 1'b0; clr = 1'b0; op = OP_READ; addr = '0; data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        logic [92:0] got;
        logic [92:0] exp;
        apply_reset();
        @(negedge clk);
        got = {busy, done, valid, full, map_out, data_out, next_code};
        exp = {4'b0000, 12'h000, 64'h0, 13'h0100};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_write_read();
        int lat;
        sb_q.push_back({1'b1, 12'h483, 64'h4241, 1'b1});
        issue(OP_WRITE, 12'h483, 64'h4241);
        wait_done(5, lat);
        n_cmp++;
        if (lat != 1) begin n_fail++; $display("FAIL write_latency: got %0d expected 1", lat); end

        sb_q.push_back({1'b1, 12'h483, 64'h4241, 1'b1});
        issue(OP_READ, 12'h483, 64'h0);
        wait_done(5, lat);
        n_cmp++;
        if (lat != 1) begin n_fail++; $display("FAIL read_latency: got %0d expected 1", lat); end
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %0b expected 1", busy); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, valid, map_out, data_out} !== {1'b0, 1'b1, 12'h483, 64'h4241}) begin
            n_fail++;
            $display("FAIL read_hold: got busy=%0b valid=%0b map=%0h data=%0h expected 0 1 483 4241",
                     busy, valid, map_out, data_out);
        end

        sb_q.push_back({1'b0, 12'h257, 64'h0, 1'b0});
        issue(OP_READ, 12'h257, 64'h0);
        wait_done(5, lat);
        n_cmp++;
        if (lat != 1) begin n_fail++; $display("FAIL read_invalid_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_append_search();
        int lat;
        sb_q.push_back({1'b1, 12'h100, 64'h4142, 1'b1});
        issue(OP_APPEND, 12'h000, 64'h4142);
        wait_done(5, lat);
        n_cmp++;
        if (lat != 1) begin n_fail++; $display("FAIL append_latency: got %0d expected 1", lat); end
        n_cmp++;
        if (next_code !== 13'h0101) begin
            n_fail++;
            $display("FAIL append_next_code: got %0h expected 101", next_code);
        end

        sb_q.push_back({1'b1, 12'h100, 64'h4142, 1'b1});
        issue(OP_SEARCH, 12'h000, 64'h4142);
        wait_done(300, lat);
        n_cmp++;
        if (lat != 258) begin n_fail++; $display("FAIL search_hit_latency: got %0d expected 258", lat); end
    endtask

    task automatic test_search_miss();
        int lat;
        sb_q.push_back({1'b0, 12'h000, 64'h0, 1'b1});
        issue(OP_SEARCH, 12'hABC, 64'hDEAD);
        lat = -1;
        for (int i = 1; i <= 4200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            // a request during the scan must be dropped, not queued
            if (i == 20) begin
                req = 1'b1; op = OP_READ; addr = 12'h483;
            end else begin
                req = 1'b0;
            end
        end
        req = 1'b0;
        n_cmp++;
        if (lat != 4097) begin n_fail++; $display("FAIL search_miss_latency: got %0d expected 4097", lat); end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL search_miss_idle: got busy=%0b expected 0", busy); end
    endtask

    task automatic test_fill_clear();
        int lat;
        int n_bad;
        apply_reset();
        n_bad = 0;
        for (int i = 0; i < 3840; i++) begin
            sb_q.push_back({1'b1, AW'(256 + i), DW'(i), 1'b1});
            issue(OP_APPEND, 12'h000, DW'(i));
            wait_done(5, lat);
            if (lat != 1) n_bad++;
        end
        n_cmp++;
        if (n_bad != 0) begin n_fail++; $display("FAIL fill_latency: got %0d late appends expected 0", n_bad); end
        @(negedge clk);
        n_cmp++;
        if ({map_out, full, next_code} !== {12'hFFF, 1'b1, 13'h1000}) begin
            n_fail++;
            $display("FAIL fill_state: got map=%0h full=%0b next=%0h expected fff 1 1000",
                     map_out, full, next_code);
        end

        sb_q.push_back({1'b0, 12'h000, 64'h0, 1'b0});
        issue(OP_APPEND, 12'h000, 64'h55);
        wait_done(5, lat);
        n_cmp++;
        if (lat != 1) begin n_fail++; $display("FAIL full_append_latency: got %0d expected 1", lat); end
        @(negedge clk);
        n_cmp++;
        if ({full, next_code} !== {1'b1, 13'h1000}) begin
            n_fail++;
            $display("FAIL full_append_ptr: got full=%0b next=%0h expected 1 1000", full, next_code);
        end

        // clr together with req: clear happens, the append is dropped
        @(negedge clk);
        clr = 1'b1; req = 1'b1; op = OP_APPEND; data_in = 64'h77;
        @(posedge clk);
        #1;
        clr = 1'b0; req = 1'b0; op = OP_READ; data_in = '0;
        @(negedge clk);
        n_cmp++;
        if ({busy, full, next_code} !== {1'b0, 1'b0, 13'h0100}) begin
            n_fail++;
            $display("FAIL clear_state: got busy=%0b full=%0b next=%0h expected 0 0 100",
                     busy, full, next_code);
        end
        repeat (3) @(negedge clk);

        sb_q.push_back({1'b0, 12'h100, 64'h0, 1'b0});
        issue(OP_READ, 12'h100, 64'h0);
        wait_done(5, lat);
        n_cmp++;
        if (lat != 1) begin n_fail++; $display("FAIL clear_read_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_reset_mid_search();
        int lat;
        sb_q.push_back({1'b1, 12'h200, 64'h4241, 1'b1});
        issue(OP_WRITE, 12'h200, 64'h4241);
        wait_done(5, lat);
        n_cmp++;
        if (lat != 1) begin n_fail++; $display("FAIL rs_write_latency: got %0d expected 1", lat); end

        issue(OP_SEARCH, 12'h000, 64'h4241);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rs_async: got busy=%0b done=%0b valid=%0b expected 0 0 0", busy, done, valid);
        end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;

        sb_q.push_back({1'b0, 12'h000, 64'h0, 1'b1});
        issue(OP_SEARCH, 12'h000, 64'h4241);
        wait_done(4200, lat);
        n_cmp++;
        if (lat != 4097) begin n_fail++; $display("FAIL rs_search_latency: got %0d expected 4097", lat); end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; clr = 1'b0; op = OP_READ; addr = '0; data_in = '0;
        test_reset();
        test_write_read();
        test_append_search();
        test_search_miss();
        test_fill_clear();
        test_reset_mid_search();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
